// File: rtl/cmd_pkg.sv
// Shared constants for the UART command path: sizes, reader states, control bytes and the command table.
// Also used by the printer's string ROM. Strings are stored first character in bits [7:0].
package cmd_pkg;

    localparam int NUM_CMDS = 4;
    localparam int MAX_LEN  = 8;
    localparam int CMD_ID_W = $clog2(NUM_CMDS);
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int STR_W    = MAX_LEN * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MATCH   = 2'd1,
        DISCARD = 2'd2
    } reader_state_t;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    localparam logic [CMD_ID_W-1:0] CMD_ID_HELP   = CMD_ID_W'(0);
    localparam logic [CMD_ID_W-1:0] CMD_ID_LED    = CMD_ID_W'(1);
    localparam logic [CMD_ID_W-1:0] CMD_ID_STATUS = CMD_ID_W'(2);
    localparam logic [CMD_ID_W-1:0] CMD_ID_RESET  = CMD_ID_W'(3);

    // Characters are concatenated last-first so the first one lands in the low byte.
    localparam logic [STR_W-1:0] CMD_STR_HELP   = STR_W'({"p", "l", "e", "h"});
    localparam logic [STR_W-1:0] CMD_STR_LED    = STR_W'({"d", "e", "l"});
    localparam logic [STR_W-1:0] CMD_STR_STATUS = STR_W'({"s", "u", "t", "a", "t", "s"});
    localparam logic [STR_W-1:0] CMD_STR_RESET  = STR_W'({"t", "e", "s", "e", "r"});

    localparam logic [LEN_W-1:0] CMD_LEN_HELP   = LEN_W'(4);
    localparam logic [LEN_W-1:0] CMD_LEN_LED    = LEN_W'(3);
    localparam logic [LEN_W-1:0] CMD_LEN_STATUS = LEN_W'(6);
    localparam logic [LEN_W-1:0] CMD_LEN_RESET  = LEN_W'(5);

    function automatic logic is_terminator(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

    function automatic logic is_backspace(input logic [7:0] b);
        return (b == BS) || (b == DEL);
    endfunction

endpackage

// File: rtl/cmd_table.sv
// Combinational command table lookup: entry index to padded string and length.
module cmd_table
    import cmd_pkg::*;
(
    input  logic [CMD_ID_W-1:0] index,
    output logic [STR_W-1:0]    cmd_str,
    output logic [LEN_W-1:0]    cmd_len
);

    always_comb begin
        cmd_str = '0;
        cmd_len = '0;
        case (index)
            CMD_ID_HELP: begin
                cmd_str = CMD_STR_HELP;
                cmd_len = CMD_LEN_HELP;
            end
            CMD_ID_LED: begin
                cmd_str = CMD_STR_LED;
                cmd_len = CMD_LEN_LED;
            end
            CMD_ID_STATUS: begin
                cmd_str = CMD_STR_STATUS;
                cmd_len = CMD_LEN_STATUS;
            end
            CMD_ID_RESET: begin
                cmd_str = CMD_STR_RESET;
                cmd_len = CMD_LEN_RESET;
            end
            default: begin
                cmd_str = '0;
                cmd_len = '0;
            end
        endcase
    end

endmodule

// File: rtl/cmd_reader.sv
// UART command line reader: buffers a line, scans the command table one entry per cycle on a terminator.
// Define CMD_READER_ECHO_EN to build the echo path; otherwise echo_data/echo_enable are tied to 0.
module cmd_reader
    import cmd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [CMD_ID_W-1:0] cmd_id,
    output logic                cmd_valid,
    output logic                cmd_error,
    output logic [1:0]          reader_state,
    output logic [LEN_W-1:0]    line_len,
    output logic [7:0]          echo_data,
    output logic                echo_enable
);

    reader_state_t          state_reg, state_next;
    logic [LEN_W-1:0]       line_len_reg, line_len_next;
    logic [CMD_ID_W-1:0]    scan_reg, scan_next;
    logic [CMD_ID_W-1:0]    cmd_id_reg, cmd_id_next;
    logic                   disc_err_reg, disc_err_next;

    logic                   rx_term, rx_bs, in_idle, line_full;
    logic                   term_go, bs_dec, store_byte, overflow;
    logic                   scan_last, line_hit;
    logic [STR_W-1:0]       tbl_str;
    logic [LEN_W-1:0]       tbl_len;
    logic [MAX_LEN-1:0]     byte_eq;

    cmd_table u_cmd_table (
        .index   (scan_reg),
        .cmd_str (tbl_str),
        .cmd_len (tbl_len)
    );

    always_comb begin
        rx_term    = is_terminator(rx_data);
        rx_bs      = is_backspace(rx_data);
        in_idle    = rx_valid && (state_reg == IDLE);
        line_full  = (line_len_reg == LEN_W'(MAX_LEN));
        term_go    = in_idle && rx_term && (line_len_reg != '0);
        bs_dec     = in_idle && rx_bs && (line_len_reg != '0);
        store_byte = in_idle && !rx_term && !rx_bs && !line_full;
        overflow   = in_idle && !rx_term && !rx_bs && line_full;
        scan_last  = (scan_reg == CMD_ID_W'(NUM_CMDS - 1));
    end

    // Each byte slot owns its register; positions past the entry length always compare equal.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_line
            logic [7:0] byte_reg;

            always_ff @(posedge clk) begin
                if (store_byte && (line_len_reg == LEN_W'(gi)))
                    byte_reg <= rx_data;
            end

            assign byte_eq[gi] = (LEN_W'(gi) >= tbl_len) || (byte_reg == tbl_str[gi*8 +: 8]);
        end
    endgenerate

    assign line_hit = (line_len_reg == tbl_len) && (&byte_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            line_len_reg <= '0;
            scan_reg     <= '0;
            cmd_id_reg   <= '0;
            disc_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            line_len_reg <= line_len_next;
            scan_reg     <= scan_next;
            cmd_id_reg   <= cmd_id_next;
            disc_err_reg <= disc_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        line_len_next = line_len_reg;
        scan_next     = scan_reg;
        cmd_id_next   = cmd_id_reg;
        disc_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (term_go) begin
                    state_next = MATCH;
                    scan_next  = '0;
                end else if (overflow) begin
                    state_next = DISCARD;
                end else if (bs_dec) begin
                    line_len_next = line_len_reg - LEN_W'(1);
                end else if (store_byte) begin
                    line_len_next = line_len_reg + LEN_W'(1);
                end
            end
            MATCH: begin
                if (line_hit) begin
                    cmd_id_next   = scan_reg;
                    line_len_next = '0;
                    state_next    = IDLE;
                end else if (scan_last) begin
                    line_len_next = '0;
                    state_next    = IDLE;
                end else begin
                    scan_next = scan_reg + CMD_ID_W'(1);
                end
            end
            DISCARD: begin
                // The error is registered so it pulses in the cycle after the terminator.
                if (rx_valid && rx_term) begin
                    disc_err_next = 1'b1;
                    line_len_next = '0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid    = (state_reg == MATCH) && line_hit;
        cmd_error    = ((state_reg == MATCH) && !line_hit && scan_last) || disc_err_reg;
        cmd_id       = cmd_valid ? scan_reg : cmd_id_reg;
        reader_state = state_reg;
        line_len     = line_len_reg;
    end

`ifdef CMD_READER_ECHO_EN
    logic [7:0] echo_data_reg, echo_data_next;
    logic       echo_enable_reg, echo_enable_next;

    always_comb begin
        echo_enable_next = store_byte || bs_dec || term_go;
        echo_data_next   = echo_data_reg;
        if (store_byte)
            echo_data_next = rx_data;
        else if (bs_dec)
            echo_data_next = BS;
        else if (term_go)
            echo_data_next = LF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_data_reg   <= '0;
            echo_enable_reg <= 1'b0;
        end else begin
            echo_data_reg   <= echo_data_next;
            echo_enable_reg <= echo_enable_next;
        end
    end

    assign echo_data   = echo_data_reg;
    assign echo_enable = echo_enable_reg;
`else
    assign echo_data   = '0;
    assign echo_enable = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_reader.sv
// Self-checking bench for cmd_reader: directed command lines plus random lines against a queue-based line model.
module tb_cmd_reader;

    localparam int TB_MAX_LEN  = 8;
    localparam int TB_NUM_CMDS = 4;
    localparam int WINDOW      = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [1:0] cmd_id;
    logic       cmd_valid;
    logic       cmd_error;
    logic [1:0] reader_state;
    logic [3:0] line_len;
    logic [7:0] echo_data;
    logic       echo_enable;

    cmd_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_id       (cmd_id),
        .cmd_valid    (cmd_valid),
        .cmd_error    (cmd_error),
        .reader_state (reader_state),
        .line_len     (line_len),
        .echo_data    (echo_data),
        .echo_enable  (echo_enable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model: the line is a byte queue, commands are plain strings.
    string        cmd_names [TB_NUM_CMDS] = '{"help", "led", "status", "reset"};
    byte unsigned line_q [$];
    bit           discarding = 1'b0;
    int           last_id = 0;

    function automatic bit line_equals(input int k);
        string s = cmd_names[k];
        if (s.len() != line_q.size())
            return 1'b0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != line_q[i])
                return 1'b0;
        return 1'b1;
    endfunction

    // kind: 0 no pulse, 1 cmd_valid, 2 cmd_error; off: cycles after the accepting edge.
    task automatic model_step(input logic [7:0] b, output int kind, output int off, output int id,
                              output int een, output int edat);
        bit term = (b == 8'h0D) || (b == 8'h0A);
        bit bsp  = (b == 8'h08) || (b == 8'h7F);
        kind = 0; off = 0; id = 0; een = 0; edat = 0;
        if (discarding) begin
            if (term) begin
                kind = 2; off = 1;
                discarding = 1'b0;
                line_q.delete();
            end
        end else if (term) begin
            if (line_q.size() > 0) begin
                kind = 2; off = TB_NUM_CMDS;
                for (int k = 0; k < TB_NUM_CMDS; k++)
                    if (kind == 2 && line_equals(k)) begin
                        kind = 1; off = k + 1; id = k;
                    end
                if (kind == 1)
                    last_id = id;
                line_q.delete();
                een = 1; edat = 8'h0A;
            end
        end else if (bsp) begin
            if (line_q.size() > 0) begin
                void'(line_q.pop_back());
                een = 1; edat = 8'h08;
            end
        end else if (line_q.size() < TB_MAX_LEN) begin
            line_q.push_back(b);
            een = 1; edat = int'(b);
        end else begin
            discarding = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int ek, eoff, eid, een, edat;
        int ok = 0, ooff = 0, oid = 0, npulse = 0, both = 0;
        int oen = 0, odat = 0, necho = 0;
        model_step(b, ek, eoff, eid, een, edat);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        for (int j = 1; j <= WINDOW; j++) begin
            if (cmd_valid && cmd_error)
                both++;
            if (cmd_valid || cmd_error) begin
                npulse++;
                if (npulse == 1) begin
                    ok   = cmd_valid ? 1 : 2;
                    ooff = j;
                    oid  = int'(cmd_id);
                end
            end
            if (echo_enable) begin
                necho++;
                if (necho == 1) begin
                    oen  = j;
                    odat = int'(echo_data);
                end
            end
            if (j < WINDOW) begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("pulse_kind", ok, ek);
        check_eq("pulse_count", npulse, (ek != 0) ? 1 : 0);
        if (ek != 0)
            check_eq("pulse_offset", ooff, eoff);
        if (ek == 1)
            check_eq("cmd_id_pulse", oid, eid);
        check_eq("valid_and_error", both, 0);
        check_eq("cmd_id_hold", int'(cmd_id), last_id);
        check_eq("line_len", int'(line_len), line_q.size());
        check_eq("reader_state", int'(reader_state), discarding ? 2 : 0);
`ifdef CMD_READER_ECHO_EN
        check_eq("echo_count", necho, een);
        if (een != 0) begin
            check_eq("echo_offset", oen, 1);
            check_eq("echo_data", odat, edat);
        end
`else
        check_eq("echo_count", necho, 0);
        check_eq("echo_data_tied", int'(echo_data), 0);
`endif
        $display("byte %02h: pulse=%0d off=%0d id=%0d len=%0d state=%0d echo_exp=%0d/%02h",
                 b, ok, ooff, oid, line_len, reader_state, een, edat[7:0]);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_state"}, int'(reader_state), 0);
        check_eq({tag, "_line_len"}, int'(line_len), 0);
        check_eq({tag, "_cmd_id"}, int'(cmd_id), 0);
        check_eq({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        check_eq({tag, "_cmd_error"}, int'(cmd_error), 0);
        check_eq({tag, "_echo_data"}, int'(echo_data), 0);
        check_eq({tag, "_echo_enable"}, int'(echo_enable), 0);
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("async_rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        line_q.delete();
        discarding = 1'b0;
        last_id = 0;
        $display("async reset applied mid-line");
    endtask

    task automatic random_line();
        int mode = $urandom_range(0, 4);
        int k = $urandom_range(0, TB_NUM_CMDS - 1);
        string s = cmd_names[k];
        byte unsigned seq [$];
        for (int i = 0; i < s.len(); i++)
            seq.push_back(s[i]);
        case (mode)
            1: seq[$urandom_range(0, seq.size() - 1)] = 8'(8'h61 + $urandom_range(0, 25));
            2: begin
                int n = $urandom_range(0, 11);
                seq.delete();
                for (int i = 0; i < n; i++)
                    seq.push_back(8'(($urandom_range(0, 7) == 0 ? 8'h41 : 8'h61) + $urandom_range(0, 25)));
            end
            3: begin
                int p = $urandom_range(0, seq.size());
                seq.insert(p, ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F);
                seq.insert(p, 8'(8'h61 + $urandom_range(0, 25)));
            end
            4: seq.push_back(8'(8'h61 + $urandom_range(0, 25)));
            default: ;
        endcase
        foreach (seq[i])
            send_byte(seq[i]);
        send_byte(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
        if ($urandom_range(0, 3) == 0)
            send_byte(8'h0A);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        send_str("led");      send_byte(8'h0D);
        send_str("reset");    send_byte(8'h0D); send_byte(8'h0A);
        send_str("ledx");     send_byte(8'h0D);
        send_str("help");     send_byte(8'h0D);
        send_str("helpme123"); send_byte(8'h0D);
        send_str("lex");      send_byte(8'h08); send_str("d"); send_byte(8'h0D);
        send_byte(8'h7F);
        send_str("Help");     send_byte(8'h0D);
        send_str("status");   send_byte(8'h0A);
        send_str("sta");
        async_reset_pulse();
        send_str("led");      send_byte(8'h0D);

        repeat (40) random_line();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
